peas_ctrl: RTL and testbench
============================

# peas_ctrl

Pea object controller: spawns, moves, collision-checks and retires the single pea drawn by the pea renderer. It drives the renderer's `peas_valid`/`peas_x`/`peas_y`/`peas_type` inputs once per video frame, and reports pea-eaten events to the scoring logic. It sits between the game-state logic (frame tick, run/restart, bird position) and the pea pixel path.

## Interface
- `SCREEN_W`, 640: spawn x coordinate; the pea enters from the right edge.
- `SPEED`, 2: pixels moved left per frame.
- `SPAWN_GAP`, 60: frames between pea retire and next spawn.
- `Y_MIN`, 100: top of the spawn band; `peas_y` = `Y_MIN` + 0..255.
- `PEAS_SIZE`, 15: pea box edge in pixels.
- `BIRD_W`, 34 / `BIRD_H`, 24: bird box size.
- `FLASH_FRAMES`, 16: eaten-flash length; used only with `PEAS_EAT_FLASH_EN`.

- `clk` in 1: system clock, one clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_tick` in 1: one-cycle pulse per frame (vsync).
- `game_run` in 1: 1 = advance; 0 = freeze.
- `game_restart` in 1: one-cycle pulse; retires the pea and restarts the gap.
- `bird_x`, `bird_y` in 10 each: bird box top-left, in pixels.
- `peas_valid` out 1: pea visible.
- `peas_x`, `peas_y` out 10 each: pea box top-left; y grows downward.
- `peas_type` out 3: sprite plane select 0..7.
- `peas_eaten` out 1: one-cycle pulse on collision.
- `pea_count` out 8: count of eaten peas, saturates at 255.

## Operation
- **States:**
  - GAP: counter `gap_cnt`.
  - ACTIVE.
  - FLASH: exists only with the macro.
- **Reset:**
  - State = GAP, `gap_cnt` = `SPAWN_GAP`, LFSR = 16'hACE1.
  - All outputs 0.
- **LFSR:** 16-bit Fibonacci, x^16+x^14+x^13+x^11+1. Steps every clock regardless of `game_run`.
- **Frame-tick events:** events below occur only on a clock where `frame_tick` = 1 and `game_run` = 1. Otherwise the state, counters and position hold.
- **GAP:**
  - If `gap_cnt` = 0: spawn. `peas_valid` = 1, `peas_x` = `SCREEN_W`, `peas_y` = `Y_MIN` + lfsr[7:0], `peas_type` = lfsr[10:8]. Go to ACTIVE.
  - Otherwise `gap_cnt` decrements.
- **ACTIVE**, evaluated on the pre-move position, in priority order:
  1. Collision: the inclusive boxes [`peas_x`, `peas_x`+`PEAS_SIZE`-1] × [`peas_y`, +`PEAS_SIZE`-1] and [`bird_x`, +`BIRD_W`-1] × [`bird_y`, +`BIRD_H`-1] overlap. Then: `peas_eaten` pulses, `pea_count`++ (saturating), pea retires.
  2. Exit: `peas_x` < `SPEED`. Pea retires without `peas_eaten`.
  3. Otherwise `peas_x` -= `SPEED`.
- **Retire:** `peas_valid` = 0, `gap_cnt` = `SPAWN_GAP`, go to GAP.
- **Restart:** `game_restart` acts on any clock and is independent of tick and run. Effect is the same as retire, with no count and no eaten pulse. Restart beats a coincident collision.
- **Arithmetic:** comparisons use 11-bit intermediates so sums never wrap. `peas_x` never underflows.

## Timing
- All outputs are registered. Each update is visible the cycle after the tick edge.
- `peas_eaten` is high for exactly one cycle per collision.
- Spawn occurs on the (`SPAWN_GAP`+1)th qualifying tick after retire.
- `SPAWN_GAP` = 0 → spawn on the first tick.
- Bird inputs are sampled only on the tick clock.
- Asynchronous reset mid-operation clears every output immediately.

## Configuration
- **Macro:** `PEAS_EAT_FLASH_EN`.
- **Defined:**
  - On collision, go to FLASH instead of retiring. `peas_eaten` and `pea_count` behave as without the macro.
  - The pea is frozen in place.
  - `peas_valid` toggles every 4 qualifying ticks: first low for 4, then high for 4, and so on.
  - After `FLASH_FRAMES` ticks, retire.
  - Restart aborts FLASH.
- **Undefined:** no FLASH state. Collision retires immediately.

## Structure
- **Package `peas_pkg`:** state enum (GAP, ACTIVE, FLASH), 10-bit coordinate width, default screen/bird/pea size constants.
- **Sub-module `peas_lfsr`:** 16-bit LFSR with seed parameter; ports `clk`, `rst_n`, `lfsr` out 16.

## Test plan
All scenarios use defaults.

- **Reset and spawn:** reset, `game_run` = 1, bird at y = 450.
  - Ticks 1–60: `peas_valid` = 0.
  - Tick 61: `peas_valid` = 1, `peas_x` = 640, 100 ≤ `peas_y` ≤ 355, `peas_type` = lfsr[10:8].
- **Movement:** 10 ticks after spawn → `peas_x` = 620, `peas_y` unchanged.
- **Exit:** bird at y = 450.
  - Tick 320 after spawn: `peas_x` = 0.
  - Next tick: `peas_valid` = 0, no `peas_eaten`, `pea_count` = 0.
  - Respawn 61 ticks later.
- **Collision:** `bird_x` = 300, `bird_y` = `peas_y`.
  - No hit at `peas_x` = 334.
  - Tick at `peas_x` = 332: `peas_eaten` is a single pulse, `pea_count` = 1, `peas_valid` = 0 next cycle.
  - With the macro: `peas_valid` pattern 0,1,0,1 over 16 ticks, `peas_x` stays 332, then retire.
- **Freeze and restart:**
  - `game_run` = 0 for 20 ticks at `peas_x` = 500 → unchanged.
  - `game_restart` → `peas_valid` = 0 the next cycle, gap reloaded to 60.
- **Reset mid-ACTIVE:** assert `rst_n` between clock edges → all outputs 0 before the next edge. Spawn sequence restarts.

Source files
------------

// File: rtl/peas_pkg.sv
// peas_pkg: shared state type, coordinate width and default geometry for the
// pea controller (peas_ctrl) and its LFSR (peas_lfsr).
package peas_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CW1     = COORD_W + 1;

  localparam int unsigned DEF_SCREEN_W     = 640;
  localparam int unsigned DEF_SPEED        = 2;
  localparam int unsigned DEF_SPAWN_GAP    = 60;
  localparam int unsigned DEF_Y_MIN        = 100;
  localparam int unsigned DEF_PEAS_SIZE    = 15;
  localparam int unsigned DEF_BIRD_W       = 34;
  localparam int unsigned DEF_BIRD_H       = 24;
  localparam int unsigned DEF_FLASH_FRAMES = 16;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    GAP,
    ACTIVE,
    FLASH
  } peas_state_t;

  // Inclusive 1-D overlap of [a, a+aw-1] and [b, b+bw-1]; one extra bit so
  // the far edges never wrap.
  function automatic logic span_overlap(input logic [COORD_W-1:0] a,
                                        input int unsigned        aw,
                                        input logic [COORD_W-1:0] b,
                                        input int unsigned        bw);
    logic [CW1-1:0] a_lo, a_hi, b_lo, b_hi;
    a_lo = {1'b0, a};
    b_lo = {1'b0, b};
    a_hi = a_lo + CW1'(aw - 1);
    b_hi = b_lo + CW1'(bw - 1);
    return (a_lo <= b_hi) && (b_lo <= a_hi);
  endfunction

endpackage

// File: rtl/peas_lfsr.sv
// peas_lfsr: free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1,
// shifting right with feedback into bit 15. Steps every clock.
module peas_lfsr
  import peas_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q, lfsr_d;

  // Next value: taps 16,14,13,11 map to bits 0,2,3,5 of the right-shifting register.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  // State register, seeded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/peas_ctrl.sv
// peas_ctrl: spawns, moves, collision-checks and retires the single pea.
// Optional eaten-flash phase is built with macro PEAS_EAT_FLASH_EN.
module peas_ctrl
  import peas_pkg::*;
#(
  parameter int unsigned SCREEN_W     = DEF_SCREEN_W,
  parameter int unsigned SPEED        = DEF_SPEED,
  parameter int unsigned SPAWN_GAP    = DEF_SPAWN_GAP,
  parameter int unsigned Y_MIN        = DEF_Y_MIN,
  parameter int unsigned PEAS_SIZE    = DEF_PEAS_SIZE,
  parameter int unsigned BIRD_W       = DEF_BIRD_W,
  parameter int unsigned BIRD_H       = DEF_BIRD_H,
  parameter int unsigned FLASH_FRAMES = DEF_FLASH_FRAMES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               game_run,
  input  logic               game_restart,
  input  logic [COORD_W-1:0] bird_x,
  input  logic [COORD_W-1:0] bird_y,
  output logic               peas_valid,
  output logic [COORD_W-1:0] peas_x,
  output logic [COORD_W-1:0] peas_y,
  output logic [2:0]         peas_type,
  output logic               peas_eaten,
  output logic [7:0]         pea_count
);

  localparam int unsigned GAP_W = $clog2(SPAWN_GAP + 2);

  logic [15:0]        lfsr;
  logic               lfsr_unused;
  logic               tick;
  logic               hit;

  peas_state_t        state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               valid_q, valid_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [2:0]         type_q, type_d;
  logic               eaten_q, eaten_d;
  logic [7:0]         count_q, count_d;

`ifdef PEAS_EAT_FLASH_EN
  localparam int unsigned FLASH_W = ($clog2(FLASH_FRAMES + 1) < 3) ? 3 : $clog2(FLASH_FRAMES + 1);
  logic [FLASH_W-1:0] flash_q, flash_d;
  logic [FLASH_W-1:0] flash_next;
`else
  logic [7:0]         flash_frames_unused;
  assign flash_frames_unused = 8'(FLASH_FRAMES);
`endif

  peas_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:11];
  assign tick        = frame_tick & game_run;
  assign hit         = span_overlap(x_q, PEAS_SIZE, bird_x, BIRD_W) &&
                       span_overlap(y_q, PEAS_SIZE, bird_y, BIRD_H);

  // Next-state: restart first, then tick-qualified GAP/ACTIVE/FLASH behaviour.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    type_d  = type_q;
    eaten_d = 1'b0;
    count_d = count_q;
`ifdef PEAS_EAT_FLASH_EN
    flash_d    = flash_q;
    flash_next = flash_q + FLASH_W'(1);
`endif
    if (game_restart) begin
      state_d = GAP;
      valid_d = 1'b0;
      gap_d   = GAP_W'(SPAWN_GAP);
    end else if (tick) begin
      case (state_q)
        GAP: begin
          if (gap_q == '0) begin
            state_d = ACTIVE;
            valid_d = 1'b1;
            x_d     = COORD_W'(SCREEN_W);
            y_d     = COORD_W'(Y_MIN) + COORD_W'(lfsr[7:0]);
            type_d  = lfsr[10:8];
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
        ACTIVE: begin
          if (hit) begin
            eaten_d = 1'b1;
            if (count_q != '1) count_d = count_q + 8'd1;
            valid_d = 1'b0;
`ifdef PEAS_EAT_FLASH_EN
            state_d = FLASH;
            flash_d = '0;
`else
            state_d = GAP;
            gap_d   = GAP_W'(SPAWN_GAP);
`endif
          end else if ({1'b0, x_q} < CW1'(SPEED)) begin
            state_d = GAP;
            valid_d = 1'b0;
            gap_d   = GAP_W'(SPAWN_GAP);
          end else begin
            x_d = x_q - COORD_W'(SPEED);
          end
        end
`ifdef PEAS_EAT_FLASH_EN
        FLASH: begin
          // Blink phase comes from bit 2 of the tick count: 4 low, 4 high, ...
          flash_d = flash_next;
          if (flash_next == FLASH_W'(FLASH_FRAMES)) begin
            state_d = GAP;
            valid_d = 1'b0;
            gap_d   = GAP_W'(SPAWN_GAP);
          end else begin
            valid_d = flash_next[2];
          end
        end
`endif
        default: begin
          state_d = GAP;
          valid_d = 1'b0;
          gap_d   = GAP_W'(SPAWN_GAP);
        end
      endcase
    end
  end

  // Registered FSM state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GAP;
      gap_q   <= GAP_W'(SPAWN_GAP);
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      type_q  <= '0;
      eaten_q <= 1'b0;
      count_q <= '0;
`ifdef PEAS_EAT_FLASH_EN
      flash_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      type_q  <= type_d;
      eaten_q <= eaten_d;
      count_q <= count_d;
`ifdef PEAS_EAT_FLASH_EN
      flash_q <= flash_d;
`endif
    end
  end

  assign peas_valid = valid_q;
  assign peas_x     = x_q;
  assign peas_y     = y_q;
  assign peas_type  = type_q;
  assign peas_eaten = eaten_q;
  assign pea_count  = count_q;

endmodule

// File: tb/tb_peas_ctrl.sv
// tb_peas_ctrl: directed scenarios plus randomized play, checked against a
// behavioural model of the pea rules kept in this file.
module tb_peas_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       game_run = 1'b0;
  logic       game_restart = 1'b0;
  logic [9:0] bird_x = '0;
  logic [9:0] bird_y = '0;
  logic       peas_valid;
  logic [9:0] peas_x;
  logic [9:0] peas_y;
  logic [2:0] peas_type;
  logic       peas_eaten;
  logic [7:0] pea_count;

  int total = 0;
  int bad   = 0;

  // Model state: mode 0 = waiting, 1 = flying, 2 = flashing.
  logic [15:0] m_lfsr;
  int          m_mode, m_gap, m_x, m_y, m_type, m_count, m_flash;
  bit          m_valid, m_eaten;

  peas_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .game_run     (game_run),
    .game_restart (game_restart),
    .bird_x       (bird_x),
    .bird_y       (bird_y),
    .peas_valid   (peas_valid),
    .peas_x       (peas_x),
    .peas_y       (peas_y),
    .peas_type    (peas_type),
    .peas_eaten   (peas_eaten),
    .pea_count    (pea_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [32:0] model_vec();
    return {m_valid, 10'(m_x), 10'(m_y), 3'(m_type), m_eaten, 8'(m_count)};
  endfunction

  task automatic model_reset();
    m_lfsr = 16'hACE1; m_mode = 0; m_gap = 60;
    m_x = 0; m_y = 0; m_type = 0; m_count = 0; m_flash = 0;
    m_valid = 0; m_eaten = 0;
  endtask

  task automatic model_retire();
    m_mode = 0; m_valid = 0; m_gap = 60;
  endtask

  // One clock of the game rules, using the inputs presented at that edge.
  task automatic model_clock(input bit tk, input bit rs);
    bit hit;
    m_eaten = 0;
    if (rs) model_retire();
    else if (tk && game_run) begin
      if (m_mode == 0) begin
        if (m_gap == 0) begin
          m_mode = 1; m_valid = 1; m_x = 640;
          m_y = 100 + int'(m_lfsr[7:0]);
          m_type = int'(m_lfsr[10:8]);
        end else m_gap--;
      end else if (m_mode == 1) begin
        hit = (m_x <= int'(bird_x) + 33) && (int'(bird_x) <= m_x + 14) &&
              (m_y <= int'(bird_y) + 23) && (int'(bird_y) <= m_y + 14);
        if (hit) begin
          m_eaten = 1;
          if (m_count < 255) m_count++;
`ifdef PEAS_EAT_FLASH_EN
          m_mode = 2; m_flash = 0; m_valid = 0;
`else
          model_retire();
`endif
        end else if (m_x < 2) model_retire();
        else m_x -= 2;
      end else begin
        m_flash++;
        if (m_flash == 16) model_retire();
        else m_valid = bit'((m_flash / 4) % 2);
      end
    end
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  endtask

  // One clock: drive at negedge, edge, update model, return to negedge.
  task automatic step(input bit tk, input bit rs);
    frame_tick = tk; game_restart = rs;
    @(posedge clk);
    model_clock(tk, rs);
    @(negedge clk);
    frame_tick = 0; game_restart = 0;
  endtask

  task automatic do_tick();
    repeat ($urandom_range(0, 2)) step(0, 0);
    step(1, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({peas_valid, peas_x, peas_y, peas_type, peas_eaten, pea_count} !== 33'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {peas_valid, peas_x, peas_y, peas_type, peas_eaten, pea_count});
    end
  endtask

  task automatic test_spawn();
    game_run = 1; bird_y = 450; bird_x = 10'($urandom_range(0, 1023));
    for (int i = 1; i <= 60; i++) begin
      do_tick();
      total++;
      if (peas_valid !== 1'b0) begin bad++; $display("FAIL spawn_gap_valid tick %0d: got %b want 0", i, peas_valid); end
    end
    do_tick();
    total++;
    if (peas_valid !== 1'b1) begin bad++; $display("FAIL spawn_valid: got %b want 1", peas_valid); end
    total++;
    if (peas_x !== 10'd640) begin bad++; $display("FAIL spawn_x: got %0d want 640", peas_x); end
    total++;
    if (peas_y !== 10'(m_y) || peas_y < 10'd100 || peas_y > 10'd355) begin
      bad++; $display("FAIL spawn_y: got %0d want %0d", peas_y, m_y);
    end
    total++;
    if (peas_type !== 3'(m_type)) begin bad++; $display("FAIL spawn_type: got %0d want %0d", peas_type, m_type); end
  endtask

  task automatic test_movement();
    int y0;
    y0 = m_y;
    repeat (10) do_tick();
    total++;
    if (peas_x !== 10'd620) begin bad++; $display("FAIL move_x: got %0d want 620", peas_x); end
    total++;
    if (peas_y !== 10'(y0)) begin bad++; $display("FAIL move_y: got %0d want %0d", peas_y, y0); end
  endtask

  task automatic test_exit();
    repeat (310) do_tick();
    total++;
    if (peas_x !== 10'd0 || peas_valid !== 1'b1) begin
      bad++; $display("FAIL exit_x0: got x=%0d v=%b want x=0 v=1", peas_x, peas_valid);
    end
    do_tick();
    total++;
    if ({peas_valid, peas_eaten, pea_count} !== 10'h0) begin
      bad++; $display("FAIL exit_retire: got v=%b e=%b c=%0d want 0 0 0", peas_valid, peas_eaten, pea_count);
    end
    for (int i = 1; i <= 60; i++) begin
      do_tick();
      total++;
      if (peas_valid !== 1'b0) begin bad++; $display("FAIL exit_gap tick %0d: got %b want 0", i, peas_valid); end
    end
    do_tick();
    total++;
    if ({peas_valid, peas_x, peas_y, peas_type} !== {1'b1, 10'd640, 10'(m_y), 3'(m_type)}) begin
      bad++; $display("FAIL exit_respawn: got v=%b x=%0d y=%0d t=%0d want 1 640 %0d %0d",
                      peas_valid, peas_x, peas_y, peas_type, m_y, m_type);
    end
  endtask

  task automatic test_collision();
    int guard;
    bird_x = 10'd300; bird_y = 10'(m_y);
    guard = 0;
    while (m_x != 334 && guard < 400) begin do_tick(); guard++; end
    total++;
    if (guard >= 400 || peas_x !== 10'd334) begin bad++; $display("FAIL col_reach334: got %0d want 334", peas_x); end
    do_tick();
    total++;
    if (peas_eaten !== 1'b0 || peas_x !== 10'd332) begin
      bad++; $display("FAIL col_nohit334: got e=%b x=%0d want e=0 x=332", peas_eaten, peas_x);
    end
    do_tick();
    total++;
    if (peas_eaten !== 1'b1 || pea_count !== 8'd1 || peas_valid !== 1'b0) begin
      bad++; $display("FAIL col_hit: got e=%b c=%0d v=%b want 1 1 0", peas_eaten, pea_count, peas_valid);
    end
    step(0, 0);
    total++;
    if (peas_eaten !== 1'b0) begin bad++; $display("FAIL col_pulse_width: got %b want 0", peas_eaten); end
`ifdef PEAS_EAT_FLASH_EN
    for (int k = 1; k <= 16; k++) begin
      do_tick();
      total++;
      if (peas_valid !== ((k < 16) ? bit'((k / 4) % 2) : 1'b0) || peas_x !== 10'd332) begin
        bad++; $display("FAIL flash_tick %0d: got v=%b x=%0d want v=%b x=332", k, peas_valid, peas_x, m_valid);
      end
    end
`endif
    bird_y = 10'd450;
  endtask

  task automatic test_random();
    bit tk, rs;
    int hits;
    hits = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        bird_x = 10'(m_x - 40 + int'($urandom_range(0, 60)));
        bird_y = 10'(m_y - 26 + int'($urandom_range(0, 45)));
      end else begin
        bird_x = 10'($urandom_range(0, 1023));
        bird_y = 10'($urandom_range(0, 1023));
      end
      game_run = ($urandom_range(0, 3) != 0);
      tk = ($urandom_range(0, 1) == 1);
      rs = ($urandom_range(0, 63) == 0);
      step(tk, rs);
      if (m_eaten) hits++;
      total++;
      if ({peas_valid, peas_x, peas_y, peas_type, peas_eaten, pea_count} !== model_vec()) begin
        bad++; $display("FAIL random cycle %0d: got %h want %h", i,
                        {peas_valid, peas_x, peas_y, peas_type, peas_eaten, pea_count}, model_vec());
      end
    end
    game_run = 1; bird_y = 10'd450; bird_x = 10'd0;
  endtask

  task automatic test_freeze_restart();
    int guard;
    step(0, 1);
    total++;
    if (peas_valid !== 1'b0) begin bad++; $display("FAIL fr_initial_restart: got %b want 0", peas_valid); end
    repeat (61) do_tick();
    total++;
    if (peas_valid !== 1'b1 || peas_x !== 10'd640) begin
      bad++; $display("FAIL fr_spawn: got v=%b x=%0d want 1 640", peas_valid, peas_x);
    end
    guard = 0;
    while (m_x != 500 && guard < 200) begin do_tick(); guard++; end
    game_run = 0;
    repeat (20) do_tick();
    total++;
    if (peas_x !== 10'd500 || peas_valid !== 1'b1) begin
      bad++; $display("FAIL freeze_x: got x=%0d v=%b want 500 1", peas_x, peas_valid);
    end
    game_run = 1;
    step(0, 1);
    total++;
    if (peas_valid !== 1'b0) begin bad++; $display("FAIL restart_valid: got %b want 0", peas_valid); end
    for (int i = 1; i <= 60; i++) begin
      do_tick();
      total++;
      if (peas_valid !== 1'b0) begin bad++; $display("FAIL restart_gap tick %0d: got %b want 0", i, peas_valid); end
    end
    do_tick();
    total++;
    if (peas_valid !== 1'b1) begin bad++; $display("FAIL restart_respawn: got %b want 1", peas_valid); end
  endtask

  task automatic test_reset_mid();
    repeat (5) do_tick();
    #2 rst_n = 0;
    #1;
    total++;
    if ({peas_valid, peas_x, peas_y, peas_type, peas_eaten, pea_count} !== 33'h0) begin
      bad++; $display("FAIL midreset_async: got %h want 0",
                      {peas_valid, peas_x, peas_y, peas_type, peas_eaten, pea_count});
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 1; i <= 60; i++) begin
      do_tick();
      total++;
      if (peas_valid !== 1'b0) begin bad++; $display("FAIL midreset_gap tick %0d: got %b want 0", i, peas_valid); end
    end
    do_tick();
    total++;
    if ({peas_valid, peas_x, peas_y, peas_type} !== {1'b1, 10'd640, 10'(m_y), 3'(m_type)}) begin
      bad++; $display("FAIL midreset_respawn: got v=%b x=%0d y=%0d t=%0d want 1 640 %0d %0d",
                      peas_valid, peas_x, peas_y, peas_type, m_y, m_type);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_spawn();
    test_movement();
    test_exit();
    test_collision();
    test_random();
    test_freeze_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
